// File: rtl/pio_arb_if.sv
// rtl/pio_arb_if.sv - PIO arbiter bus: two-master command/read-return side and downstream PIO command port.
interface pio_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic [1:0]          m_req;
  logic [1:0]          m_rw;
  logic [2*ADDR_W-1:0] m_addr;
  logic [2*DATA_W-1:0] m_wdata;
  logic [1:0]          m_gnt;
  logic [1:0]          m_rd_vld;
  logic [DATA_W-1:0]   m_rd_data;
  logic                m_rd_err;
  logic                s_cmd_vld;
  logic                s_rw;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_data_w;
  logic                s_rd_vld;
  logic [DATA_W-1:0]   s_data_r;
  logic                busy;

  modport slave (
    input  m_req, m_rw, m_addr, m_wdata, s_rd_vld, s_data_r,
    output m_gnt, m_rd_vld, m_rd_data, m_rd_err, s_cmd_vld, s_rw, s_addr, s_data_w, busy
  );

  modport master (
    output m_req, m_rw, m_addr, m_wdata, s_rd_vld, s_data_r,
    input  m_gnt, m_rd_vld, m_rd_data, m_rd_err, s_cmd_vld, s_rw, s_addr, s_data_w, busy
  );
endinterface

// File: rtl/pio_arb.sv
// rtl/pio_arb.sv - two-master round-robin PIO arbiter, one command outstanding.
// Optional read timeout enabled by defining PIO_ARB_TIMEOUT_EN.
module pio_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int TMO_CYCLES = 16
) (
  input logic      clk,
  input logic      reset,
  pio_arb_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEAD_BEEF);

  if (TMO_CYCLES < 1) begin : g_tmo_chk
    $error("pio_arb: TMO_CYCLES must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              cmd_vld_q, cmd_vld_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              win;
  logic              tmo_hit;

  // rr_q names the master that wins when both request
  always_comb begin
    win = (bus.m_req == 2'b11) ? rr_q : bus.m_req[1];
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    gnt_d     = 2'b00;
    rd_vld_d  = 2'b00;
    rd_data_d = rd_data_q;
    cmd_vld_d = 1'b0;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (|bus.m_req) begin
          owner_d   = win;
          rr_d      = ~win;
          gnt_d     = win ? 2'b10 : 2'b01;
          cmd_vld_d = 1'b1;
          rw_d      = win ? bus.m_rw[1] : bus.m_rw[0];
          addr_d    = win ? bus.m_addr[2*ADDR_W-1:ADDR_W] : bus.m_addr[ADDR_W-1:0];
          wdata_d   = win ? bus.m_wdata[2*DATA_W-1:DATA_W] : bus.m_wdata[DATA_W-1:0];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = rw_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.s_rd_vld || tmo_hit) begin
          rd_vld_d  = owner_q ? 2'b10 : 2'b01;
          rd_data_d = bus.s_rd_vld ? bus.s_data_r : TMO_DATA;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      gnt_q     <= 2'b00;
      rd_vld_q  <= 2'b00;
      rd_data_q <= '0;
      cmd_vld_q <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      cmd_vld_q <= cmd_vld_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

`ifdef PIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_err_q, rd_err_d;

  assign tmo_hit = (state_q == WAIT_RD) && (cnt_q == CW'(TMO_CYCLES - 1));

  // A real return in the expiry cycle wins over the timeout
  always_comb begin
    cnt_d    = '0;
    rd_err_d = 1'b0;
    if (state_q == WAIT_RD) begin
      cnt_d    = cnt_q + CW'(1);
      rd_err_d = tmo_hit && !bus.s_rd_vld;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign bus.m_rd_err = rd_err_q;
`else
  assign tmo_hit      = 1'b0;
  assign bus.m_rd_err = 1'b0;
`endif

  assign bus.m_gnt     = gnt_q;
  assign bus.m_rd_vld  = rd_vld_q;
  assign bus.m_rd_data = rd_data_q;
  assign bus.s_cmd_vld = cmd_vld_q;
  assign bus.s_rw      = rw_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_data_w  = wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pio_arb.sv
// tb/tb_pio_arb.sv - directed bench for pio_arb: grants, round-robin, read returns, reset abort, timeout/hold.
`timescale 1ns/1ps
module tb_pio_arb;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  logic cmd_prev;

  pio_arb_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  pio_arb #(.ADDR_W(16), .DATA_W(32), .TMO_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},     64'(bus.m_gnt),     64'h0);
    check({tag, " rd_vld"},  64'(bus.m_rd_vld),  64'h0);
    check({tag, " rd_data"}, 64'(bus.m_rd_data), 64'h0);
    check({tag, " rd_err"},  64'(bus.m_rd_err),  64'h0);
    check({tag, " cmd_vld"}, 64'(bus.s_cmd_vld), 64'h0);
    check({tag, " s_rw"},    64'(bus.s_rw),      64'h0);
    check({tag, " s_addr"},  64'(bus.s_addr),    64'h0);
    check({tag, " s_data"},  64'(bus.s_data_w),  64'h0);
    check({tag, " busy"},    64'(bus.busy),      64'h0);
  endtask

  // Protocol invariants sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      check("cmd_b2b", 64'(cmd_prev & bus.s_cmd_vld), 64'h0);
      check("err_wo_vld", 64'(bus.m_rd_err & ~(|bus.m_rd_vld)), 64'h0);
    end
    cmd_prev <= bus.s_cmd_vld;
  end

  initial begin
    int  cnt;
    logic seen;
    n_chk = 0;
    n_err = 0;
    cmd_prev = 1'b0;
    reset = 1'b1;
    bus.m_req = 2'b00;
    bus.m_rw = 2'b00;
    bus.m_addr = '0;
    bus.m_wdata = '0;
    bus.s_rd_vld = 1'b0;
    bus.s_data_r = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Both masters read together after reset: master 0 first
    bus.m_req = 2'b11; bus.m_rw = 2'b00;
    bus.m_addr = {16'h0222, 16'h0111};
    tick();
    check("rr0 gnt", 64'(bus.m_gnt), 64'h1);
    check("rr0 cmd", 64'(bus.s_cmd_vld), 64'h1);
    check("rr0 rw", 64'(bus.s_rw), 64'h0);
    check("rr0 addr", 64'(bus.s_addr), 64'h0111);
    bus.m_req = 2'b10;
    tick();
    check("rr0 wait gnt", 64'(bus.m_gnt), 64'h0);
    check("rr0 wait busy", 64'(bus.busy), 64'h1);
    bus.s_rd_vld = 1'b1; bus.s_data_r = 32'hA0A0_0000;
    tick();
    bus.s_rd_vld = 1'b0;
    check("rr0 rd_vld", 64'(bus.m_rd_vld), 64'h1);
    check("rr0 rd_data", 64'(bus.m_rd_data), 64'hA0A0_0000);
    check("rr0 rd_err", 64'(bus.m_rd_err), 64'h0);
    check("rr0 no gnt1", 64'(bus.m_gnt), 64'h0);
    check("rr0 busy", 64'(bus.busy), 64'h0);
    tick();
    check("rr1 gnt", 64'(bus.m_gnt), 64'h2);
    check("rr1 addr", 64'(bus.s_addr), 64'h0222);
    check("rr1 rd_vld", 64'(bus.m_rd_vld), 64'h0);
    bus.m_req = 2'b00;
    tick();
    bus.s_rd_vld = 1'b1; bus.s_data_r = 32'hA1A1_1111;
    tick();
    bus.s_rd_vld = 1'b0;
    check("rr1 rd_vld", 64'(bus.m_rd_vld), 64'h2);
    check("rr1 rd_data", 64'(bus.m_rd_data), 64'hA1A1_1111);

    // Master 1 read, 1-cycle downstream: return 3 cycles after request
    tick();
    bus.m_req = 2'b10; bus.m_rw = 2'b00; bus.m_addr = {16'h1000, 16'h0000};
    tick();
    check("m1rd gnt", 64'(bus.m_gnt), 64'h2);
    check("m1rd addr", 64'(bus.s_addr), 64'h1000);
    check("m1rd lat1", 64'(bus.m_rd_vld), 64'h0);
    bus.m_req = 2'b00;
    tick();
    check("m1rd lat2", 64'(bus.m_rd_vld), 64'h0);
    bus.s_rd_vld = 1'b1; bus.s_data_r = 32'hCAFE_0001;
    tick();
    bus.s_rd_vld = 1'b0;
    check("m1rd lat3", 64'(bus.m_rd_vld), 64'h2);
    check("m1rd data", 64'(bus.m_rd_data), 64'hCAFE_0001);
    check("m1rd err", 64'(bus.m_rd_err), 64'h0);
    tick();
    check("m1rd pulse", 64'(bus.m_rd_vld), 64'h0);

    // Master 0 write, one-cycle command
    bus.m_req = 2'b01; bus.m_rw = 2'b01;
    bus.m_addr = {16'h0000, 16'h8005}; bus.m_wdata = {32'h0, 32'h1234_5678};
    tick();
    check("wr gnt", 64'(bus.m_gnt), 64'h1);
    check("wr cmd", 64'(bus.s_cmd_vld), 64'h1);
    check("wr rw", 64'(bus.s_rw), 64'h1);
    check("wr addr", 64'(bus.s_addr), 64'h8005);
    check("wr data", 64'(bus.s_data_w), 64'h1234_5678);
    bus.m_req = 2'b00;
    tick();
    check("wr cmd off", 64'(bus.s_cmd_vld), 64'h0);
    check("wr gnt off", 64'(bus.m_gnt), 64'h0);
    check("wr idle", 64'(bus.busy), 64'h0);

    // Both writing back-to-back: alternation, one command per 2 cycles
    bus.m_req = 2'b11; bus.m_rw = 2'b11;
    bus.m_addr = {16'h00B1, 16'h00B0}; bus.m_wdata = {32'hB1, 32'hB0};
    tick();
    check("wt gnt a", 64'(bus.m_gnt), 64'h2);
    check("wt addr a", 64'(bus.s_addr), 64'h00B1);
    tick();
    check("wt gap a", 64'(bus.s_cmd_vld), 64'h0);
    tick();
    check("wt gnt b", 64'(bus.m_gnt), 64'h1);
    check("wt data b", 64'(bus.s_data_w), 64'hB0);
    tick();
    check("wt gap b", 64'(bus.s_cmd_vld), 64'h0);
    tick();
    check("wt gnt c", 64'(bus.m_gnt), 64'h2);
    bus.m_req = 2'b00;
    tick();

    // Spurious return while idle
    bus.s_rd_vld = 1'b1; bus.s_data_r = 32'h5555_5555;
    tick();
    check("spur rd_vld", 64'(bus.m_rd_vld), 64'h0);
    check("spur busy", 64'(bus.busy), 64'h0);
    tick();
    bus.s_rd_vld = 1'b0;
    check("spur rd_vld2", 64'(bus.m_rd_vld), 64'h0);

    // Reset in WAIT_RD drops the read; late return ignored
    bus.m_req = 2'b01; bus.m_rw = 2'b00;
    tick();
    bus.m_req = 2'b00;
    tick();
    check("rst busy pre", 64'(bus.busy), 64'h1);
    reset = 1'b1;
    #1;
    check_all_zero("rst wait");
    bus.s_rd_vld = 1'b1; bus.s_data_r = 32'h7777_7777;
    tick();
    reset = 1'b0;
    tick();
    check("rst late vld", 64'(bus.m_rd_vld), 64'h0);
    bus.s_rd_vld = 1'b0;
    tick();
    check("rst late vld2", 64'(bus.m_rd_vld), 64'h0);

    // Silent downstream
    bus.m_req = 2'b10; bus.m_rw = 2'b00;
    tick();
    bus.m_req = 2'b00;
    cnt = 1;
    seen = 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
    while (!seen && cnt < 40) begin
      tick();
      cnt++;
      seen = |bus.m_rd_vld;
    end
    check("tmo seen", 64'(seen), 64'h1);
    check("tmo cycle", 64'(cnt), 64'd18);
    check("tmo vld", 64'(bus.m_rd_vld), 64'h2);
    check("tmo err", 64'(bus.m_rd_err), 64'h1);
    check("tmo data", 64'(bus.m_rd_data), 64'hDEAD_BEEF);
    tick();
    check("tmo busy", 64'(bus.busy), 64'h0);
`else
    while (cnt < 30) begin
      tick();
      cnt++;
      seen = seen | (|bus.m_rd_vld);
    end
    check("hold no vld", 64'(seen), 64'h0);
    check("hold busy", 64'(bus.busy), 64'h1);
    check("hold err", 64'(bus.m_rd_err), 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("hold rst busy", 64'(bus.busy), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
